// File: rtl/seq_div16by8_pkg.sv
// Shared widths, state encoding and constants for the sequential 16/8 restoring divider.
package seq_div16by8_pkg;

  localparam int unsigned N_DVD = 16;
  localparam int unsigned N_DVS = 8;
  localparam int unsigned CNT_W = 4;

  localparam logic [N_DVD-1:0] DIV0_QUOT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/seq_div16by8_trial_sub9.sv
// Ripple-borrow trial subtractor (d = a - b), bit-sliced like a full-adder chain.
module trial_sub9 #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] d,
  output logic         borrow
);

  logic [W:0] w_bc;

  assign w_bc[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign d[i]      = a[i] ^ b[i] ^ w_bc[i];
    assign w_bc[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_bc[i]);
  end

  assign borrow = w_bc[W];

endmodule

// File: rtl/seq_div16by8.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake,
// divide-by-zero short-circuits straight to DONE.
module seq_div16by8
  import seq_div16by8_pkg::*;
#(
  parameter int unsigned N_DVD = seq_div16by8_pkg::N_DVD,
  parameter int unsigned N_DVS = seq_div16by8_pkg::N_DVS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_DVD-1:0] dividend,
  input  logic [N_DVS-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [N_DVD-1:0] quotient,
  output logic [N_DVS-1:0] remainder,
  output logic             div_zero
);

  state_t r_state;
  state_t w_next;

  logic [N_DVS-1:0] r_r;
  logic [N_DVD-1:0] r_q;
  logic [N_DVS-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic [N_DVD-1:0] r_quot;
  logic [N_DVS-1:0] r_rem;
  logic             r_dz;

  logic [N_DVS:0]   w_t;
  logic [N_DVS:0]   w_d;
  logic             w_borrow;
  logic [N_DVS:0]   w_r_nxt;
  logic [N_DVD-1:0] w_q_nxt;
  logic             w_accept;
  logic             w_dvs_zero;
  logic             w_last;
  logic             w_unused;

  // R is held 8 bits wide: R < divisor keeps bit 8 of every restored value at 0.
  assign w_t        = {r_r, r_q[N_DVD-1]};
  assign w_r_nxt    = w_borrow ? w_t : w_d;
  assign w_q_nxt    = {r_q[N_DVD-2:0], ~w_borrow};
  assign w_unused   = w_r_nxt[N_DVS];
  assign w_accept   = start && (r_state != ST_RUN);
  assign w_dvs_zero = (divisor == '0);
  assign w_last     = (r_cnt == CNT_W'(N_DVD - 1));

  trial_sub9 #(.W(N_DVS + 1)) u_sub (
    .a      (w_t),
    .b      ({1'b0, r_dvs}),
    .d      (w_d),
    .borrow (w_borrow)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start)                  w_next = w_dvs_zero ? ST_DONE : ST_RUN;
        else if (r_state == ST_DONE) w_next = ST_IDLE;
      end
      ST_RUN:  if (w_last) w_next = ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r    <= '0;
      r_q    <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dz   <= 1'b0;
    end else if (w_accept) begin
      r_r   <= '0;
      r_q   <= dividend;
      r_dvs <= divisor;
      r_cnt <= '0;
      if (w_dvs_zero) begin
        r_quot <= DIV0_QUOT;
        r_rem  <= dividend[N_DVS-1:0];
        r_dz   <= 1'b1;
      end
    end else if (r_state == ST_RUN) begin
      r_r   <= w_r_nxt[N_DVS-1:0];
      r_q   <= w_q_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_quot <= w_q_nxt;
        r_rem  <= w_r_nxt[N_DVS-1:0];
        r_dz   <= 1'b0;
      end
    end
  end

  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign div_zero  = r_dz;

endmodule

// File: tb/tb_seq_div16by8.sv
// Directed scoreboard bench for seq_div16by8: drivers push expected results and completion
// cycle, a negedge monitor pops and compares on every done pulse.
module tb_seq_div16by8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        busy, done, div_zero;
  logic [15:0] quotient;
  logic [7:0]  remainder;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          at;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  seq_div16by8 #(.N_DVD(16), .N_DVS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", {31'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, "_latency"}, cyc, e.at);
        chk({e.nm, "_quot"}, {16'd0, quotient}, {16'd0, e.q});
        chk({e.nm, "_rem"}, {24'd0, remainder}, {24'd0, e.r});
        chk({e.nm, "_dz"}, {31'd0, div_zero}, {31'd0, e.dz});
        chk({e.nm, "_busy_in_done"}, {31'd0, busy}, 32'd0);
      end
    end
  end

  // Drive one request for a single edge; k is the accepting edge number.
  task automatic issue(input string nm, input logic [15:0] a, input logic [7:0] b,
                       input logic [15:0] eq, input logic [7:0] er, input logic edz,
                       input bit track, output int k);
    exp_t e;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    k = cyc + 1;
    if (track) begin
      e.q = eq; e.r = er; e.dz = edz; e.nm = nm;
      e.at = edz ? k : k + 16;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input string nm);
    int budget = 0;
    while (sb.size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() != 0) begin
      chk({nm, "_timeout"}, sb.size(), 32'd0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int k, k2;
    exp_t e;

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quot", {16'd0, quotient}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic: 1000 / 7 = 142 r 6
    issue("basic", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 1'b1, k);
    chk("basic_busy_first", {31'd0, busy}, 32'd1);
    wait_until(k + 15);
    chk("basic_busy_last", {31'd0, busy}, 32'd1);
    drain("basic");

    issue("ffff_1", 16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 1'b1, k);
    drain("ffff_1");
    issue("00ff_ff", 16'h00FF, 8'hFF, 16'h0001, 8'h00, 1'b0, 1'b1, k);
    drain("00ff_ff");
    issue("5_10", 16'h0005, 8'h0A, 16'h0000, 8'h05, 1'b0, 1'b1, k);
    drain("5_10");

    // Divide by zero completes the cycle after acceptance without busy
    issue("div0", 16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, 1'b1, k);
    chk("div0_busy", {31'd0, busy}, 32'd0);
    drain("div0");

    // Start and new operands mid-run must be ignored
    issue("interf", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 1'b1, k);
    wait_until(k + 5);
    start = 1'b1; dividend = 16'd9; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    drain("interf");

    // Back-to-back with start held: 100/9 = 11 r 1, then 255/16 = 15 r 15
    @(negedge clk);
    start = 1'b1; dividend = 16'd100; divisor = 8'd9;
    k = cyc + 1;
    e.q = 16'd11; e.r = 8'd1; e.dz = 1'b0; e.at = k + 16; e.nm = "b2b_1";
    sb.push_back(e);
    k2 = k + 17;
    e.q = 16'd15; e.r = 8'd15; e.dz = 1'b0; e.at = k2 + 16; e.nm = "b2b_2";
    sb.push_back(e);
    @(negedge clk);
    dividend = 16'd255; divisor = 8'd16;
    wait_until(k2);
    start = 1'b0;
    chk("b2b_busy_after_reaccept", {31'd0, busy}, 32'd1);
    drain("b2b");

    // Async reset mid-run abandons the operation: no done, outputs cleared at once
    issue("rstrun", 16'hABCD, 8'h0F, 16'h0, 8'h0, 1'b0, 1'b0, k);
    wait_until(k + 8);
    #2 rst_n = 1'b0;
    #1;
    chk("rstrun_busy", {31'd0, busy}, 32'd0);
    chk("rstrun_done", {31'd0, done}, 32'd0);
    chk("rstrun_quot", {16'd0, quotient}, 32'd0);
    chk("rstrun_rem", {24'd0, remainder}, 32'd0);
    chk("rstrun_dz", {31'd0, div_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rstrun_quot_held", {16'd0, quotient}, 32'd0);

    // 0xABCD = 43981 = 15 * 2932 + 1
    issue("fresh", 16'hABCD, 8'h0F, 16'h0B74, 8'h01, 1'b0, 1'b1, k);
    drain("fresh");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
